// File: rtl/pipeline_writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_writeback_stage
//  Description : Registered writeback stage between MEM and the register
//                file. Aligns and extends load data, selects the writeback
//                source, registers the result under valid/stall/flush
//                control and counts retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_writeback_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32,
  parameter int OFF_W      = $clog2(XLEN/8)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  valid_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [XLEN-1:0]       pcsrc_i,
  input  logic [XLEN-1:0]       mem_data_read_i,
  input  logic [XLEN-1:0]       alu_result_i,
  input  logic [XLEN-1:0]       offset_i,
  input  logic [1:0]            dmem_to_reg_i,
  input  logic [1:0]            load_size_i,
  input  logic                  load_unsigned_i,
  input  logic [OFF_W-1:0]      byte_offset_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  reg_write_i,
  output logic                  valid_o,
  output logic                  reg_write_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic [XLEN-1:0]       write_data_reg_o,
  output logic [CNT_W-1:0]      retire_count_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [OFF_W-1:0]      load_off;
  logic [XLEN-1:0]       load_shifted;
  logic                  sign_fill;
  logic [XLEN-1:0]       byte_ext;
  logic [XLEN-1:0]       half_ext;
  logic [XLEN-1:0]       word_ext;
  logic [XLEN-1:0]       dword_ext;
  logic [XLEN-1:0]       load_data;
  logic [XLEN-1:0]       wb_data;

  logic                  valid_q;
  logic                  reg_write_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]       data_q;
  logic [CNT_W-1:0]      retire_q;

  // Align the byte offset down to the access size (misaligned reads snap to the aligned unit)
  always_comb begin
    load_off = byte_offset_i;
    case (load_size_i)
      2'b01:   load_off[0]   = 1'b0;
      2'b10:   load_off[1:0] = 2'b00;
      2'b11:   load_off      = '0;
      default: load_off      = byte_offset_i;
    endcase
  end

  assign load_shifted = mem_data_read_i >> {load_off, 3'b000};
  assign sign_fill    = ~load_unsigned_i;
  assign byte_ext     = {{(XLEN-8){sign_fill & load_shifted[7]}},   load_shifted[7:0]};
  assign half_ext     = {{(XLEN-16){sign_fill & load_shifted[15]}}, load_shifted[15:0]};

  // Word/double extraction differs only in whether the datapath is wider than a word
  if (XLEN > 32) begin : g_wide
    assign word_ext  = {{(XLEN-32){sign_fill & load_shifted[31]}}, load_shifted[31:0]};
    assign dword_ext = load_shifted;
  end else begin : g_narrow
    // On a 32-bit datapath a double request behaves as a word load
    assign word_ext  = load_shifted;
    assign dword_ext = word_ext;
  end

  // Pick the extended load value for the requested access size
  always_comb begin
    load_data = byte_ext;
    case (load_size_i)
      2'b00:   load_data = byte_ext;
      2'b01:   load_data = half_ext;
      2'b10:   load_data = word_ext;
      default: load_data = dword_ext;
    endcase
  end

  // Writeback source mux
  always_comb begin
    wb_data = load_data;
    case (dmem_to_reg_i)
      2'b00:   wb_data = load_data;
      2'b01:   wb_data = alu_result_i;
      2'b10:   wb_data = pcsrc_i;
      default: wb_data = offset_i;
    endcase
  end

  // Stage register: flush kills the incoming instruction even under stall; stall alone holds
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      data_q      <= '0;
    end else if (flush_i) begin
      valid_q     <= 1'b0;
    end else if (!stall_i) begin
      valid_q     <= valid_i;
      reg_write_q <= reg_write_i;
      rd_q        <= rd_addr_i;
      data_q      <= wb_data;
    end
  end

  // Count a held valid instruction once, on the edge where it leaves the stage
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      retire_q <= '0;
    end else if (valid_q && (!stall_i || flush_i)) begin
      retire_q <= retire_q + CNT_ONE;
    end
  end

  assign valid_o          = valid_q;
  assign reg_write_o      = valid_q & reg_write_q & (rd_q != '0);
  assign rd_addr_o        = rd_q;
  assign write_data_reg_o = data_q;
  assign retire_count_o   = retire_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_writeback_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pipeline_writeback_stage
//  Description : Self-checking bench for pipeline_writeback_stage, with a
//                32-bit and a 64-bit (4-bit counter) instance sharing stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_writeback_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid, stall, flush, uns, we;
  logic [1:0]  sel, size;
  logic [2:0]  off;
  logic [4:0]  rd;
  logic [63:0] mem, alu, pc, offs;

  logic        v32, w32, v64, w64;
  logic [4:0]  rd32, rd64;
  logic [31:0] d32, c32;
  logic [63:0] d64;
  logic [3:0]  c64;

  int total = 0;
  int bad   = 0;

  // Reference slot: one instruction position plus an unbounded retire tally
  logic        m_v, m_we, m_known;
  logic [4:0]  m_rd;
  logic [63:0] m_d32, m_d64;
  longint      m_cnt;

  always #5 clk = ~clk;

  pipeline_writeback_stage #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(32)) dut32 (
    .clk_i(clk), .reset_i(rst), .valid_i(valid), .stall_i(stall), .flush_i(flush),
    .pcsrc_i(pc[31:0]), .mem_data_read_i(mem[31:0]), .alu_result_i(alu[31:0]),
    .offset_i(offs[31:0]), .dmem_to_reg_i(sel), .load_size_i(size),
    .load_unsigned_i(uns), .byte_offset_i(off[1:0]), .rd_addr_i(rd),
    .reg_write_i(we), .valid_o(v32), .reg_write_o(w32), .rd_addr_o(rd32),
    .write_data_reg_o(d32), .retire_count_o(c32));

  pipeline_writeback_stage #(.XLEN(64), .REG_ADDR_W(5), .CNT_W(4)) dut64 (
    .clk_i(clk), .reset_i(rst), .valid_i(valid), .stall_i(stall), .flush_i(flush),
    .pcsrc_i(pc), .mem_data_read_i(mem), .alu_result_i(alu),
    .offset_i(offs), .dmem_to_reg_i(sel), .load_size_i(size),
    .load_unsigned_i(uns), .byte_offset_i(off), .rd_addr_i(rd),
    .reg_write_i(we), .valid_o(v64), .reg_write_o(w64), .rd_addr_o(rd64),
    .write_data_reg_o(d64), .retire_count_o(c64));

  // Expected writeback value: loads read an access-size-aligned unit, then extend
  function automatic logic [63:0] model_wb(input int xlen, input logic [1:0] s,
      input logic [63:0] m, input logic [63:0] a, input logic [63:0] p,
      input logic [63:0] o, input logic [1:0] sz, input logic u, input logic [2:0] bo);
    int nb, start;
    logic [63:0] v, r;
    r = 64'd0;
    case (s)
      2'd1: r = a;
      2'd2: r = p;
      2'd3: r = o;
      default: begin
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : ((xlen == 64) ? 8 : 4);
        start = int'(bo) % (xlen / 8);
        start = start - (start % nb);
        v = m >> (start * 8);
        for (int i = 0; i < 64; i++)
          r[i] = (i < nb * 8) ? v[i] : (u ? 1'b0 : v[nb * 8 - 1]);
      end
    endcase
    if (xlen == 32) r[63:32] = 32'd0;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the slot is held only by a stall without flush; otherwise its occupant leaves
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_v <= 1'b0; m_we <= 1'b0; m_rd <= 5'd0; m_known <= 1'b1;
      m_d32 <= 64'd0; m_d64 <= 64'd0; m_cnt <= 0;
    end else if (!stall || flush) begin
      if (m_v) m_cnt <= m_cnt + 1;
      m_v     <= valid && !flush;
      m_we    <= we;
      m_rd    <= rd;
      m_known <= !flush;
      m_d32   <= model_wb(32, sel, mem, alu, pc, offs, size, uns, off);
      m_d64   <= model_wb(64, sel, mem, alu, pc, offs, size, uns, off);
    end
  end

  // Compare both instances to the model every cycle, away from the active edge
  always @(negedge clk) begin
    check("valid32", {63'd0, v32}, {63'd0, m_v});
    check("valid64", {63'd0, v64}, {63'd0, m_v});
    check("wen32", {63'd0, w32}, {63'd0, m_v && m_we && (m_rd != 5'd0)});
    check("wen64", {63'd0, w64}, {63'd0, m_v && m_we && (m_rd != 5'd0)});
    check("cnt32", {32'd0, c32}, 64'(m_cnt % 64'd4294967296));
    check("cnt64", {60'd0, c64}, 64'(m_cnt % 16));
    if (m_known) begin
      check("rd32", {59'd0, rd32}, {59'd0, m_rd});
      check("rd64", {59'd0, rd64}, {59'd0, m_rd});
      check("data32", {32'd0, d32}, m_d32);
      check("data64", d64, m_d64);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic st, input logic fl, input logic [1:0] s,
                        input logic [1:0] sz, input logic u, input logic [2:0] bo,
                        input logic [4:0] r, input logic w);
    valid = v; stall = st; flush = fl; sel = s; size = sz; uns = u; off = bo; rd = r; we = w;
  endtask

  initial begin
    set_in(0, 0, 0, 2'd0, 2'd0, 0, 3'd0, 5'd0, 0);
    mem = 64'd0; alu = 64'd0; pc = 64'd0; offs = 64'd0;
    repeat (2) step;
    check("rst_valid", {63'd0, v32}, 64'd0);
    check("rst_data", {32'd0, d32}, 64'd0);
    check("rst_cnt", {32'd0, c32}, 64'd0);
    rst = 1'b0;

    // Load extraction, 32-bit
    mem = 64'h0000_0000_80F1_7F82;
    set_in(1, 0, 0, 2'd0, 2'd0, 0, 3'd0, 5'd3, 1); step; check("ld_b0s", {32'd0, d32}, 64'hFFFF_FF82);
    set_in(1, 0, 0, 2'd0, 2'd0, 1, 3'd1, 5'd3, 1); step; check("ld_b1u", {32'd0, d32}, 64'h0000_007F);
    set_in(1, 0, 0, 2'd0, 2'd1, 0, 3'd2, 5'd3, 1); step; check("ld_h2s", {32'd0, d32}, 64'hFFFF_80F1);
    set_in(1, 0, 0, 2'd0, 2'd1, 0, 3'd3, 5'd3, 1); step; check("ld_h3s", {32'd0, d32}, 64'hFFFF_80F1);
    set_in(1, 0, 0, 2'd0, 2'd2, 0, 3'd1, 5'd3, 1); step; check("ld_w", {32'd0, d32}, 64'h80F1_7F82);

    // Source mux and x0 suppression
    alu = 64'h1234; pc = 64'h100; offs = 64'hFFFF_FFFF_FFFF_FFF0;
    set_in(1, 0, 0, 2'd1, 2'd0, 0, 3'd0, 5'd5, 1); step;
    check("alu_data", {32'd0, d32}, 64'h1234); check("alu_wen", {63'd0, w32}, 64'd1);
    rd = 5'd0; step;
    check("x0_wen", {63'd0, w32}, 64'd0); check("x0_data", {32'd0, d32}, 64'h1234);
    sel = 2'd2; rd = 5'd5; step; check("pc_data", {32'd0, d32}, 64'h100);
    sel = 2'd3; step; check("off_data", d64, 64'hFFFF_FFFF_FFFF_FFF0);

    // Asynchronous reset with a valid instruction held
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {63'd0, v32}, 64'd0); check("arst_wen", {63'd0, w32}, 64'd0);
    check("arst_data", {32'd0, d32}, 64'd0); check("arst_rd", {59'd0, rd32}, 64'd0);
    check("arst_cnt", {32'd0, c32}, 64'd0);
    #2 rst = 1'b0;

    // Stall: outputs frozen, single count when released
    alu = 64'hAAAA;
    set_in(1, 0, 0, 2'd1, 2'd0, 0, 3'd0, 5'd7, 1); step;
    check("st_cap", {32'd0, d32}, 64'hAAAA); check("st_cnt0", {32'd0, c32}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      alu = 64'hBBBB + 64'(i); rd = 5'd9; stall = 1'b1; step;
      check("st_hold_d", {32'd0, d32}, 64'hAAAA);
      check("st_hold_rd", {59'd0, rd32}, 64'd7);
      check("st_hold_c", {32'd0, c32}, 64'd0);
    end
    stall = 1'b0; valid = 1'b0; step;
    check("st_rel_cnt", {32'd0, c32}, 64'd1); check("st_rel_v", {63'd0, v32}, 64'd0);

    // Flush, then stall+flush over a held valid instruction
    alu = 64'hCCCC; valid = 1'b1; flush = 1'b1; step;
    check("fl_valid", {63'd0, v32}, 64'd0); check("fl_wen", {63'd0, w32}, 64'd0);
    check("fl_cnt", {32'd0, c32}, 64'd1);
    alu = 64'hDDDD; rd = 5'd7; flush = 1'b0; step;
    check("fl_next_v", {63'd0, v32}, 64'd1);
    stall = 1'b1; flush = 1'b1; step;
    check("sf_valid", {63'd0, v32}, 64'd0); check("sf_cnt", {32'd0, c32}, 64'd2);
    set_in(0, 0, 0, 2'd1, 2'd0, 0, 3'd0, 5'd7, 1); step;
    check("sf_after", {32'd0, c32}, 64'd2);

    // 64-bit loads
    mem = 64'h8000_0000_0000_0001;
    set_in(1, 0, 0, 2'd0, 2'd3, 0, 3'd0, 5'd4, 1); step;
    check("ld_d64", d64, 64'h8000_0000_0000_0001);
    set_in(1, 0, 0, 2'd0, 2'd2, 0, 3'd4, 5'd4, 1); step;
    check("ld_w64_4", d64, 64'hFFFF_FFFF_8000_0000);

    // Counter wrap on the 4-bit counter
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    set_in(1, 0, 0, 2'd1, 2'd0, 0, 3'd0, 5'd1, 1);
    repeat (18) step;
    check("wrap64", {60'd0, c64}, 64'd1);
    check("wrap32", {32'd0, c32}, 64'd17);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      valid = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      sel   = 2'($urandom_range(0, 3));
      size  = 2'($urandom_range(0, 3));
      uns   = 1'($urandom_range(0, 1));
      off   = 3'($urandom_range(0, 7));
      rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      we    = 1'($urandom_range(0, 1));
      mem   = {$urandom, $urandom};
      alu   = {$urandom, $urandom};
      pc    = {$urandom, $urandom};
      offs  = {$urandom, $urandom};
      if ($urandom_range(0, 99) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      step;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
